// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin arbiter sharing one AXI read port between two masters,
// one outstanding burst at a time, with a sticky burst-length error flag.
module axi_read_arbiter #(
    parameter int ADDR_WIDTH         = 32,
    parameter int READ_CHANNEL_WIDTH = 4,
    parameter int READ_BURST_LEN     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          m0_ARVALID,
    input  logic [ADDR_WIDTH-1:0]         m0_ARADDR,
    input  logic [READ_BURST_LEN-1:0]     m0_ARLEN,
    input  logic [2:0]                    m0_ARSIZE,
    input  logic [1:0]                    m0_ARBURST,
    output logic                          m0_ARREADY,
    output logic                          m0_RVALID,
    output logic [READ_CHANNEL_WIDTH-1:0] m0_RDATA,
    output logic                          m0_RLAST,
    output logic [1:0]                    m0_RRESP,
    input  logic                          m0_RREADY,
    input  logic                          m1_ARVALID,
    input  logic [ADDR_WIDTH-1:0]         m1_ARADDR,
    input  logic [READ_BURST_LEN-1:0]     m1_ARLEN,
    input  logic [2:0]                    m1_ARSIZE,
    input  logic [1:0]                    m1_ARBURST,
    output logic                          m1_ARREADY,
    output logic                          m1_RVALID,
    output logic [READ_CHANNEL_WIDTH-1:0] m1_RDATA,
    output logic                          m1_RLAST,
    output logic [1:0]                    m1_RRESP,
    input  logic                          m1_RREADY,
    output logic                          s_ARVALID,
    output logic [ADDR_WIDTH-1:0]         s_ARADDR,
    output logic [READ_BURST_LEN-1:0]     s_ARLEN,
    output logic [2:0]                    s_ARSIZE,
    output logic [1:0]                    s_ARBURST,
    input  logic                          s_ARREADY,
    input  logic                          s_RVALID,
    input  logic [READ_CHANNEL_WIDTH-1:0] s_RDATA,
    input  logic                          s_RLAST,
    input  logic [1:0]                    s_RRESP,
    output logic                          s_RREADY,
    output logic                          grant,
    output logic                          busy,
    output logic                          err_len
);
    localparam int CW = READ_BURST_LEN + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                    state_q;
    logic                      grant_q;
    logic                      last_grant_q;
    logic                      err_q;
    logic [READ_BURST_LEN-1:0] len_q;
    logic [CW-1:0]             beat_cnt_q;

    logic in_addr;
    logic in_data;
    logic pick;
    logic r_hs;
    logic at_len;
    logic sel_r0;
    logic sel_r1;

    assign in_addr = state_q == ADDR;
    assign in_data = state_q == DATA;
    // On a tie the master that did not win last time gets the bus.
    assign pick    = (m0_ARVALID && m1_ARVALID) ? ~last_grant_q : m1_ARVALID;
    assign r_hs    = s_RVALID && s_RREADY;
    // beat_cnt+1 == len+1 reduces to beat_cnt == len; the wider counter keeps saturation distinct.
    assign at_len  = beat_cnt_q == {1'b0, len_q};
    assign sel_r0  = in_data && !grant_q;
    assign sel_r1  = in_data && grant_q;

    assign s_ARVALID  = in_addr && (grant_q ? m1_ARVALID : m0_ARVALID);
    assign s_ARADDR   = grant_q ? m1_ARADDR  : m0_ARADDR;
    assign s_ARLEN    = grant_q ? m1_ARLEN   : m0_ARLEN;
    assign s_ARSIZE   = grant_q ? m1_ARSIZE  : m0_ARSIZE;
    assign s_ARBURST  = grant_q ? m1_ARBURST : m0_ARBURST;
    assign m0_ARREADY = in_addr && !grant_q && s_ARREADY;
    assign m1_ARREADY = in_addr && grant_q && s_ARREADY;

    assign s_RREADY   = in_data && (grant_q ? m1_RREADY : m0_RREADY);
    assign m0_RVALID  = sel_r0 && s_RVALID;
    assign m0_RDATA   = sel_r0 ? s_RDATA : '0;
    assign m0_RLAST   = sel_r0 && s_RLAST;
    assign m0_RRESP   = sel_r0 ? s_RRESP : 2'b00;
    assign m1_RVALID  = sel_r1 && s_RVALID;
    assign m1_RDATA   = sel_r1 ? s_RDATA : '0;
    assign m1_RLAST   = sel_r1 && s_RLAST;
    assign m1_RRESP   = sel_r1 ? s_RRESP : 2'b00;

    assign grant   = grant_q;
    assign busy    = state_q != IDLE;
    assign err_len = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_ARVALID || m1_ARVALID) begin
                        grant_q    <= pick;
                        len_q      <= pick ? m1_ARLEN : m0_ARLEN;
                        beat_cnt_q <= '0;
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_ARVALID && s_ARREADY) state_q <= DATA;
                end
                DATA: begin
                    if (r_hs) begin
                        if (!(&beat_cnt_q)) beat_cnt_q <= beat_cnt_q + CW'(1);
                        if (s_RLAST) begin
                            if (!at_len) err_q <= 1'b1;
                            last_grant_q <= grant_q;
                            state_q      <= IDLE;
                        end else if (at_len) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: randomized masters and slave around axi_read_arbiter, checked
// every cycle against a transaction-level model of ownership, routing and burst length.
module tb_axi_read_arbiter;
    localparam int AW = 32;
    localparam int DW = 4;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    m_arvalid = '0;
    logic [1:0]    m_arready;
    logic [1:0]    m_rvalid;
    logic [1:0]    m_rlast;
    logic [1:0]    m_rready = '0;
    logic [AW-1:0] m_araddr[2];
    logic [LW-1:0] m_arlen[2];
    logic [2:0]    m_arsize[2];
    logic [1:0]    m_arburst[2];
    logic [DW-1:0] m_rdata[2];
    logic [1:0]    m_rresp[2];

    logic          s_arvalid, s_rready;
    logic [AW-1:0] s_araddr;
    logic [LW-1:0] s_arlen;
    logic [2:0]    s_arsize;
    logic [1:0]    s_arburst;
    logic          s_arready = 1'b0;
    logic          s_rvalid = 1'b0;
    logic          s_rlast = 1'b0;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    s_rresp = '0;
    logic          grant, busy, err_len;

    axi_read_arbiter #(.ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_ARVALID(m_arvalid[0]), .m0_ARADDR(m_araddr[0]), .m0_ARLEN(m_arlen[0]),
        .m0_ARSIZE(m_arsize[0]), .m0_ARBURST(m_arburst[0]), .m0_ARREADY(m_arready[0]),
        .m0_RVALID(m_rvalid[0]), .m0_RDATA(m_rdata[0]), .m0_RLAST(m_rlast[0]),
        .m0_RRESP(m_rresp[0]), .m0_RREADY(m_rready[0]),
        .m1_ARVALID(m_arvalid[1]), .m1_ARADDR(m_araddr[1]), .m1_ARLEN(m_arlen[1]),
        .m1_ARSIZE(m_arsize[1]), .m1_ARBURST(m_arburst[1]), .m1_ARREADY(m_arready[1]),
        .m1_RVALID(m_rvalid[1]), .m1_RDATA(m_rdata[1]), .m1_RLAST(m_rlast[1]),
        .m1_RRESP(m_rresp[1]), .m1_RREADY(m_rready[1]),
        .s_ARVALID(s_arvalid), .s_ARADDR(s_araddr), .s_ARLEN(s_arlen),
        .s_ARSIZE(s_arsize), .s_ARBURST(s_arburst), .s_ARREADY(s_arready),
        .s_RVALID(s_rvalid), .s_RDATA(s_rdata), .s_RLAST(s_rlast), .s_RRESP(s_rresp),
        .s_RREADY(s_rready), .grant(grant), .busy(busy), .err_len(err_len)
    );

    int total = 0;
    int bad = 0;

    // Reference model: who owns the slave, whether its address was accepted, beats seen.
    int            owner = -1;
    int            last_g = 1;
    bit            ar_done = 0;
    int            beats = 0;
    int            own_len = 0;
    bit            err_exp = 0;
    int            s_left = 0;
    bit            req[2] = '{0, 0};
    int            gq[$];

    int req_pct[2] = '{50, 50};
    int len_min = 0, len_max = 3;
    int ar_pct = 70, rr_pct = 80, rv_pct = 80, inj_pct = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        bit be, sarv, srr, arh, rh, lastb, own;
        int o, n;
        for (int i = 0; i < 2; i++) begin
            if (!req[i] && $urandom_range(0, 99) < req_pct[i]) begin
                req[i]       = 1;
                m_araddr[i]  = $urandom;
                m_arlen[i]   = LW'($urandom_range(len_min, len_max));
                m_arsize[i]  = 3'($urandom);
                m_arburst[i] = 2'($urandom);
            end
            m_arvalid[i] = req[i];
            m_rready[i]  = $urandom_range(0, 99) < rr_pct;
        end
        s_arready = $urandom_range(0, 99) < ar_pct;
        s_rvalid  = s_left > 0 && $urandom_range(0, 99) < rv_pct;
        s_rlast   = s_left == 1;
        s_rdata   = DW'($urandom);
        s_rresp   = 2'($urandom);
        #3;
        be   = owner >= 0;
        o    = be ? owner : 0;
        sarv = be && !ar_done && m_arvalid[o];
        srr  = be && ar_done && m_rready[o];
        arh  = sarv && s_arready;
        rh   = srr && s_rvalid;
        lastb = s_rlast;
        check("busy", busy, be);
        if (be) check("grant", grant, o);
        check("err_len", err_len, err_exp);
        check("s_arvalid", s_arvalid, sarv);
        if (sarv) begin
            check("s_araddr", s_araddr, m_araddr[o]);
            check("s_arlen", s_arlen, m_arlen[o]);
            check("s_arsize", s_arsize, m_arsize[o]);
            check("s_arburst", s_arburst, m_arburst[o]);
        end
        check("s_rready", s_rready, srr);
        for (int i = 0; i < 2; i++) begin
            own = be && ar_done && i == o;
            check("m_arready", m_arready[i], sarv && i == o && s_arready);
            check("m_rvalid", m_rvalid[i], own && s_rvalid);
            if (own) begin
                check("m_rdata", m_rdata[i], s_rdata);
                check("m_rlast", m_rlast[i], s_rlast);
                check("m_rresp", m_rresp[i], s_rresp);
            end else if (be) begin
                check("idle_rdata", {m_rdata[i], m_rlast[i], m_rresp[i]}, 0);
            end
        end
        @(posedge clk);
        if (!be) begin
            if (req[0] || req[1]) begin
                owner   = (req[0] && req[1]) ? 1 - last_g : (req[1] ? 1 : 0);
                own_len = int'(m_arlen[owner]);
                ar_done = 0;
                beats   = 0;
                gq.push_back(owner);
            end
        end else if (!ar_done) begin
            if (arh) begin
                ar_done = 1;
                req[o]  = 0;
                n = own_len + 1;
                if ($urandom_range(0, 99) < inj_pct) n = ($urandom_range(0, 1) || n == 1) ? n + 1 : n - 1;
                s_left = n;
            end
        end else if (rh) begin
            beats++;
            s_left--;
            if (lastb) begin
                if (beats != own_len + 1) err_exp = 1;
                last_g = o;
                owner  = -1;
            end else if (beats == own_len + 1) begin
                err_exp = 1;
            end
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_araddr[i] = '0; m_arlen[i] = '0; m_arsize[i] = '0; m_arburst[i] = '0;
        end
        #3;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_err", err_len, 0);
        check("rst_valids", {s_arvalid, s_rready, m_arready, m_rvalid}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Both masters always requesting single-beat bursts: grants must alternate from m0.
        req_pct = '{100, 100}; len_min = 0; len_max = 0; ar_pct = 100; rr_pct = 100; rv_pct = 100;
        repeat (60) tick();
        check("rr_n", gq.size() >= 4, 1);
        for (int k = 0; k < 4; k++) check("rr_seq", (k < gq.size()) ? gq[k] : 2, k % 2);

        req_pct = '{30, 30}; len_max = 3; ar_pct = 70; rr_pct = 80; rv_pct = 80;
        repeat (400) tick();

        req_pct = '{20, 20}; len_max = 7; ar_pct = 20; rr_pct = 50; rv_pct = 90;
        repeat (400) tick();

        // Pull reset during the second beat of an ARLEN=7 burst owned by m0.
        req_pct = '{100, 0}; len_min = 7; len_max = 7; ar_pct = 100; rr_pct = 100; rv_pct = 100;
        begin
            int budget = 300;
            while (budget > 0 && !(owner == 0 && ar_done && beats == 1 && own_len == 7)) begin
                tick();
                budget--;
            end
            check("rst_wait", budget > 0, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_grant", grant, 0);
        check("arst_valids", {s_arvalid, s_rready, m_arready, m_rvalid}, 0);
        owner = -1; last_g = 1; ar_done = 0; beats = 0; err_exp = 0; s_left = 0;
        s_rvalid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        req[0] = 1; req[1] = 1;
        m_arlen[0] = '0; m_arlen[1] = '0;
        len_min = 0; len_max = 0;
        tick();
        check("tie_after_rst", {busy, grant}, 2'b10);

        // Random traffic with slave-side length errors injected.
        req_pct = '{40, 40}; len_min = 0; len_max = 4; ar_pct = 60; rr_pct = 70; rv_pct = 70; inj_pct = 30;
        repeat (400) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
